// File: rtl/fetch_if.sv
// Fetch-stage bus: imem request/response, hazard and redirect controls, IF/ID latch outputs.
// master drives the controls and memory response; slave is the fetch stage itself.
interface fetch_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        halt;
  logic        br_take;
  logic [31:0] br_npc;
  logic [15:0] br_imm16;
  logic        jump_en;
  logic [31:0] j_npc;
  logic [25:0] imm26;
  logic        jr_en;
  logic [31:0] jr_addr;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;

  modport master (
    output ihit, imemload, stall, halt, br_take, br_npc, br_imm16,
           jump_en, j_npc, imm26, jr_en, jr_addr,
    input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
  );

  modport slave (
    input  ihit, imemload, stall, halt, br_take, br_npc, br_imm16,
           jump_en, j_npc, imm26, jr_en, jr_addr,
    output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect selection and IF/ID pipeline latch.
// Runs until a decoded HALT, after which only reset restarts fetching.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  fetch_if.slave bus
);

  localparam int unsigned W = 32;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   pc, pc_n;
  logic [W-1:0]   instr_q, instr_n;
  logic [W-1:0]   npc_q, npc_n;
  logic           valid_q, valid_n;

  logic [W-1:0]   pc_plus4;
  logic [W-1:0]   br_target;
  logic [W-1:0]   j_target;
  logic [W-1:0]   redir_target;
  logic           redirect;
  logic           unused_jnpc_bits;

  assign pc_plus4  = pc + W'(4);
  assign br_target = bus.br_npc + {{14{bus.br_imm16[15]}}, bus.br_imm16, 2'b00};
  assign j_target  = {bus.j_npc[31:28], bus.imm26, 2'b00};
  assign redirect  = bus.jr_en | bus.jump_en | bus.br_take;

  // Only the region bits of the jump npc feed the target.
  assign unused_jnpc_bits = ^bus.j_npc[27:0];

  // Redirect source priority: JR, then J/JAL, then taken branch.
  always_comb begin
    redir_target = br_target;
    if (bus.jr_en) begin
      redir_target = bus.jr_addr;
    end else if (bus.jump_en) begin
      redir_target = j_target;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= RUN;
      pc      <= PC_INIT;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      instr_q <= instr_n;
      npc_q   <= npc_n;
      valid_q <= valid_n;
    end
  end

  // Event priority in RUN: redirect > halt > stall > ihit > bubble.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr_q;
    npc_n   = npc_q;
    valid_n = valid_q;
    case (state)
      RUN: begin
        if (redirect) begin
          pc_n    = redir_target;
          instr_n = '0;
          npc_n   = '0;
          valid_n = 1'b0;
        end else if (bus.halt) begin
          state_n = HALTED;
          instr_n = '0;
          npc_n   = '0;
          valid_n = 1'b0;
        end else if (bus.stall) begin
          pc_n = pc;
        end else if (bus.ihit) begin
          pc_n    = pc_plus4;
          instr_n = bus.imemload;
          npc_n   = pc_plus4;
          valid_n = 1'b1;
        end else begin
          instr_n = '0;
          npc_n   = '0;
          valid_n = 1'b0;
        end
      end
      HALTED: begin
        state_n = HALTED;
      end
    endcase
  end

  assign bus.imemREN    = (state == RUN);
  assign bus.imemaddr   = pc;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_npc   = npc_q;
  assign bus.ifid_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus randomized traffic,
// expected IF outputs come from a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  typedef struct {
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        halt;
    logic        br_take;
    logic [31:0] br_npc;
    logic [15:0] br_imm16;
    logic        jump_en;
    logic [31:0] j_npc;
    logic [25:0] imm26;
    logic        jr_en;
    logic [31:0] jr_addr;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        ren;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } exp_t;

  logic CLK;
  logic RST;
  fetch_if bus ();

  fetch_stage #(.PC_INIT(PC_INIT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  // Reference state of the fetch stage
  logic [31:0] m_pc;
  logic        m_halted;
  logic [31:0] m_instr;
  logic [31:0] m_npc;
  logic        m_valid;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pc     = PC_INIT;
    m_halted = 1'b0;
    m_instr  = 32'h0;
    m_npc    = 32'h0;
    m_valid  = 1'b0;
  endfunction

  function automatic void model_flush();
    m_instr = 32'h0;
    m_npc   = 32'h0;
    m_valid = 1'b0;
  endfunction

  // One clock of the fetch rules, written as ordered early-exit decisions
  function automatic void model_apply(stim_t s);
    int off;
    if (m_halted) return;
    if (s.jr_en) begin
      m_pc = s.jr_addr;
      model_flush();
      return;
    end
    if (s.jump_en) begin
      m_pc = (s.j_npc & 32'hF000_0000) | (32'(s.imm26) * 32'd4);
      model_flush();
      return;
    end
    if (s.br_take) begin
      off  = int'($signed(s.br_imm16)) * 4;
      m_pc = s.br_npc + 32'(off);
      model_flush();
      return;
    end
    if (s.halt) begin
      m_halted = 1'b1;
      model_flush();
      return;
    end
    if (s.stall) return;
    if (s.ihit) begin
      m_pc    = m_pc + 32'd4;
      m_instr = s.imemload;
      m_npc   = m_pc;
      m_valid = 1'b1;
      return;
    end
    model_flush();
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc    = m_pc;
    e.ren   = !m_halted;
    e.instr = m_instr;
    e.npc   = m_npc;
    e.valid = m_valid;
    return e;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.ihit = 1'b0; s.imemload = 32'h0; s.stall = 1'b0; s.halt = 1'b0;
    s.br_take = 1'b0; s.br_npc = 32'h0; s.br_imm16 = 16'h0;
    s.jump_en = 1'b0; s.j_npc = 32'h0; s.imm26 = 26'h0;
    s.jr_en = 1'b0; s.jr_addr = 32'h0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.ihit     = s.ihit;
    bus.imemload = s.imemload;
    bus.stall    = s.stall;
    bus.halt     = s.halt;
    bus.br_take  = s.br_take;
    bus.br_npc   = s.br_npc;
    bus.br_imm16 = s.br_imm16;
    bus.jump_en  = s.jump_en;
    bus.j_npc    = s.j_npc;
    bus.imm26    = s.imm26;
    bus.jr_en    = s.jr_en;
    bus.jr_addr  = s.jr_addr;
  endtask

  // Issue one cycle of stimulus and queue the state expected after the next edge
  task automatic step(input stim_t s);
    @(negedge CLK);
    drive(s);
    model_apply(s);
    sb_q.push_back(model_snapshot());
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_pc"},    bus.imemaddr,   PC_INIT);
    check({tag, "_ren"},   32'(bus.imemREN),    32'd1);
    check({tag, "_instr"}, bus.ifid_instr, 32'h0);
    check({tag, "_npc"},   bus.ifid_npc,   32'h0);
    check({tag, "_valid"}, 32'(bus.ifid_valid), 32'd0);
  endtask

  // Assert RST between edges, verify the effect without a clock, hold over one edge
  task automatic pulse_reset(string tag);
    @(negedge CLK);
    drive(idle_stim());
    #2;
    RST = 1'b1;
    #1;
    check_reset_values({tag, "_async"});
    model_reset();
    sb_q.push_back(model_snapshot());
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check({tag, "_post_ren"},  32'(bus.imemREN), 32'd1);
    check({tag, "_post_addr"}, bus.imemaddr, PC_INIT);
  endtask

  // Monitor: the DUT presents a new IF state after every rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_pc",    bus.imemaddr,        e.pc);
        check("sb_ren",   32'(bus.imemREN),    32'(e.ren));
        check("sb_instr", bus.ifid_instr,      e.instr);
        check("sb_npc",   bus.ifid_npc,        e.npc);
        check("sb_valid", 32'(bus.ifid_valid), 32'(e.valid));
      end
    end
  end

  initial begin
    stim_t s;
    logic [31:0] data [3];
    logic [31:0] held_instr;
    data[0] = 32'h11; data[1] = 32'h22; data[2] = 32'h33;

    RST = 1'b1;
    drive(idle_stim());
    model_reset();
    repeat (2) @(negedge CLK);
    check_reset_values("init");
    RST = 1'b0;
    #1;
    check("init_ren_before_edge",  32'(bus.imemREN), 32'd1);
    check("init_addr_before_edge", bus.imemaddr, PC_INIT);

    // Sequential fetch from PC 0
    for (int i = 0; i < 3; i++) begin
      s = idle_stim(); s.ihit = 1'b1; s.imemload = data[i];
      step(s);
      settle();
      check("seq_npc",   bus.ifid_npc,   32'(4 * (i + 1)));
      check("seq_instr", bus.ifid_instr, data[i]);
      check("seq_valid", 32'(bus.ifid_valid), 32'd1);
    end
    check("seq_pc", bus.imemaddr, 32'd12);

    // Stall at PC 8 holds PC and IF/ID despite ihit
    pulse_reset("rst_a");
    for (int i = 0; i < 2; i++) begin
      s = idle_stim(); s.ihit = 1'b1; s.imemload = 32'hA0 + 32'(i);
      step(s);
    end
    settle();
    held_instr = bus.ifid_instr;
    check("pre_stall_pc", bus.imemaddr, 32'd8);
    for (int i = 0; i < 2; i++) begin
      s = idle_stim(); s.ihit = 1'b1; s.stall = 1'b1; s.imemload = 32'hDEAD_BEEF;
      step(s);
      settle();
      check("stall_pc",    bus.imemaddr,   32'd8);
      check("stall_npc",   bus.ifid_npc,   32'd8);
      check("stall_instr", bus.ifid_instr, held_instr);
    end

    // Taken branch with negative offset, same-cycle ihit ignored
    s = idle_stim(); s.br_take = 1'b1; s.br_npc = 32'h100; s.br_imm16 = 16'hFFFF;
    s.ihit = 1'b1; s.imemload = 32'h5555_5555;
    step(s);
    settle();
    check("br_pc",    bus.imemaddr, 32'h0FC);
    check("br_valid", 32'(bus.ifid_valid), 32'd0);

    // Redirect priority JR > J > branch, then J alone
    s = idle_stim(); s.jr_en = 1'b1; s.jr_addr = 32'h40;
    s.jump_en = 1'b1; s.j_npc = 32'h1000_0000; s.imm26 = 26'h10;
    s.br_take = 1'b1; s.br_npc = 32'h200; s.br_imm16 = 16'h0004;
    step(s);
    settle();
    check("prio_jr_pc", bus.imemaddr, 32'h40);
    s = idle_stim(); s.jump_en = 1'b1; s.j_npc = 32'h1000_0000; s.imm26 = 26'h10;
    step(s);
    settle();
    check("prio_j_pc", bus.imemaddr, 32'h1000_0040);

    // Halt at PC 0x20, inputs ignored afterwards, reset recovers
    s = idle_stim(); s.jr_en = 1'b1; s.jr_addr = 32'h20;
    step(s);
    s = idle_stim(); s.halt = 1'b1; s.ihit = 1'b1;
    step(s);
    settle();
    check("halt_ren",   32'(bus.imemREN), 32'd0);
    check("halt_pc",    bus.imemaddr, 32'h20);
    check("halt_valid", 32'(bus.ifid_valid), 32'd0);
    s = idle_stim(); s.br_take = 1'b1; s.br_npc = 32'h300; s.ihit = 1'b1;
    step(s);
    settle();
    check("halt_br_ignored", bus.imemaddr, 32'h20);
    pulse_reset("rst_halt");

    // PC wrap, then asynchronous reset between edges
    s = idle_stim(); s.jr_en = 1'b1; s.jr_addr = 32'hFFFF_FFFC;
    step(s);
    s = idle_stim(); s.ihit = 1'b1; s.imemload = 32'h7777_0001;
    step(s);
    settle();
    check("wrap_pc",  bus.imemaddr, 32'h0);
    check("wrap_npc", bus.ifid_npc, 32'h0);
    pulse_reset("rst_wrap");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 7) == 0)) begin
        pulse_reset("rst_rand");
      end else begin
        s = idle_stim();
        s.ihit     = ($urandom_range(0, 99) < 70);
        s.imemload = $urandom();
        s.stall    = ($urandom_range(0, 99) < 20);
        s.halt     = ($urandom_range(0, 99) < 3);
        s.br_take  = ($urandom_range(0, 99) < 8);
        s.br_npc   = $urandom();
        s.br_imm16 = 16'($urandom());
        s.jump_en  = ($urandom_range(0, 99) < 5);
        s.j_npc    = $urandom();
        s.imm26    = 26'($urandom());
        s.jr_en    = ($urandom_range(0, 99) < 5);
        s.jr_addr  = $urandom() & 32'hFFFF_FFFC;
        step(s);
      end
    end

    @(negedge CLK);
    drive(idle_stim());
    repeat (2) @(negedge CLK);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
